// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - cache miss controller: lookup, 4-word line fetch, fill, completion
module cache_fill_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [14:0]  addr,
  input  logic         hit,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic [2:0]   tag,
  output logic [9:0]   index,
  output logic [1:0]   word_offset,
  output logic [127:0] MM_data,
  output logic         mem_rd,
  output logic [14:0]  mem_addr,
  output logic         stall,
  output logic         done,
  output logic [15:0]  access_count,
  output logic [15:0]  hit_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FETCH  = 3'd2,
    FILL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [14:0] addr_q;
  logic [1:0]  beat;
  logic [6:0]  slot_lsb;

  assign tag         = addr_q[14:12];
  assign index       = addr_q[11:2];
  assign word_offset = addr_q[1:0];
  assign mem_addr    = {addr_q[14:2], beat};

  // Word 0 of the line sits in the most significant slot.
  assign slot_lsb = 7'd96 - {beat, 5'd0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (req) state_nxt = LOOKUP;
      LOOKUP: begin
        stall     = 1'b1;
        state_nxt = hit ? DONE : FETCH;
      end
      FETCH: begin
        stall  = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready && beat == 2'd3) state_nxt = FILL;
      end
      FILL: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      beat         <= '0;
      MM_data      <= '0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      if (state == IDLE && req) addr_q <= addr;
      if (state == LOOKUP) begin
        beat <= 2'd0;
        if (access_count != 16'hFFFF) access_count <= access_count + 16'd1;
        if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
      if (state == FETCH && mem_ready) begin
        MM_data[slot_lsb +: 32] <= mem_rdata;
        beat                    <= beat + 2'd1;
      end
    end
  end

endmodule
